// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// State enum, MMIO upper-address pattern, starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_ISSUE,
    S_MEM_WAIT,
    S_MMIO,
    S_RESP
  } state_t;

  // Upper address bits [ADDR_W-1:8] all ones select MMIO.
  localparam logic [63:0] MMIO_BASE_HI = '1;

  localparam logic [1:0] STARVE_MAX = 2'd3;

endpackage

// File: rtl/mem_arbiter_sync2.sv
// Two-flop synchronizer for asynchronous board switches.
// Ports: clk, rst_n (async low), d (async in), q (synced out).
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (IF)
// and load/store (LS). LS has priority; IF wins after 3 LS grants
// in a row while it waits. Optional MMIO (LED/SW) when the macro
// MEM_ARB_MMIO_EN is defined.
// Ports: CLK, RST_N | IF_REQ/ADDR/ACK/RDATA | LS_REQ/WE/BE/ADDR/
// WDATA/ACK/RDATA | MEM_EN/WE/ADDR/WDATA/RDATA | SW, LED.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              LS_REQ,
  input  logic              LS_WE,
  input  logic [3:0]        LS_BE,
  input  logic [ADDR_W-1:0] LS_ADDR,
  input  logic [DATA_W-1:0] LS_WDATA,
  output logic              LS_ACK,
  output logic [DATA_W-1:0] LS_RDATA,
  output logic              MEM_EN,
  output logic [3:0]        MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic [7:0]        SW,
  output logic [7:0]        LED
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t state_q, state_d;

  logic [1:0]        starve_q;
  logic              ls_win, if_win;
  logic              grant_ls, grant_if;
  logic              mmio_hit;
  logic              src_ls_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [DATA_W-1:0] ls_now;
  logic [2:0]        lat_cnt_q;
  logic [7:0]        sw_s;
  logic              if_ack, ls_ack;

`ifdef MEM_ARB_MMIO_EN
  logic [7:0] led_q;

  sync2 #(.W(8)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (SW),
    .q     (sw_s)
  );

  assign mmio_hit =
    LS_ADDR[ADDR_W-1:8] == MMIO_BASE_HI[ADDR_W-9:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_q <= '0;
    end else if (state_q == S_MMIO && we_q && be_q[0]) begin
      led_q <= wdata_q[7:0];
    end
  end

  assign LED = led_q;
`else
  logic unused_sw;

  assign unused_sw = ^SW;
  assign sw_s      = '0;
  assign mmio_hit  = 1'b0;
  assign LED       = '0;
`endif

  // IF overrides LS only once it has been passed over STARVE_MAX times.
  assign ls_win = LS_REQ &&
                  !(starve_q == STARVE_MAX && IF_REQ);
  assign if_win = IF_REQ && !ls_win;

  always_comb begin
    state_d  = state_q;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          ls_win:  grant_ls = 1'b1;
          if_win:  grant_if = 1'b1;
          default: ;
        endcase
        if (grant_ls) begin
          state_d = mmio_hit ? S_MMIO : S_MEM_ISSUE;
        end else if (grant_if) begin
          state_d = S_MEM_ISSUE;
        end
      end
      S_MEM_ISSUE: begin
        state_d = (MEM_LAT == 1) ? S_RESP : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (lat_cnt_q == LAT_M1) state_d = S_RESP;
      end
      S_MMIO:  state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_q <= '0;
    end else if (grant_if) begin
      starve_q <= '0;
    end else if (grant_ls) begin
      if (!IF_REQ)
        starve_q <= '0;
      else if (starve_q != STARVE_MAX)
        starve_q <= starve_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src_ls_q <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (grant_ls || grant_if) begin
      src_ls_q <= grant_ls;
      we_q     <= grant_ls & LS_WE;
      be_q     <= grant_ls ? LS_BE : 4'b0;
      addr_q   <= grant_ls ? LS_ADDR : IF_ADDR;
      wdata_q  <= grant_ls ? LS_WDATA : '0;
    end
  end

  // Counts cycles since MEM_EN; RESP lands where MEM_RDATA is valid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_cnt_q <= '0;
    end else if (state_q == S_MEM_ISSUE) begin
      lat_cnt_q <= 3'd1;
    end else if (state_q == S_MEM_WAIT) begin
      lat_cnt_q <= lat_cnt_q + 3'd1;
    end
  end

  assign if_ack = (state_q == S_RESP) && !src_ls_q;
  assign ls_ack = (state_q == S_RESP || state_q == S_MMIO)
                  && src_ls_q;

  always_comb begin
    ls_now = MEM_RDATA;
    if (we_q)
      ls_now = '0;
    else if (state_q == S_MMIO)
      ls_now = {{(DATA_W-8){1'b0}}, sw_s};
  end

  // Read data passes through in the ACK cycle, then is held.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (if_ack) if_rdata_q <= MEM_RDATA;
      if (ls_ack) ls_rdata_q <= ls_now;
    end
  end

  assign IF_ACK    = if_ack;
  assign LS_ACK    = ls_ack;
  assign IF_RDATA  = if_ack ? MEM_RDATA : if_rdata_q;
  assign LS_RDATA  = ls_ack ? ls_now : ls_rdata_q;
  assign MEM_EN    = (state_q == S_MEM_ISSUE);
  assign MEM_WE    = (state_q == S_MEM_ISSUE && we_q) ?
                     be_q : 4'b0;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width, fixed at 32 when MMIO is compiled in.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, range 1..7, meaning the cycles from MEM_EN to valid MEM_RDATA.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; the ports SHALL be CLK (in, 1, rising-edge clock) and RST_N (in, 1, asynchronous active-low reset).
REQ-005 The instruction-fetch port SHALL be IF_REQ (in, 1), IF_ADDR (in, ADDR_W), IF_ACK (out, 1, one-cycle pulse) and IF_RDATA (out, DATA_W).
REQ-006 The load/store port SHALL be LS_REQ (in, 1), LS_WE (in, 1), LS_BE (in, 4, byte enables), LS_ADDR (in, ADDR_W), LS_WDATA (in, DATA_W), LS_ACK (out, 1, pulse) and LS_RDATA (out, DATA_W).
REQ-007 The memory port SHALL be MEM_EN (out, 1), MEM_WE (out, 4, per-byte write), MEM_ADDR (out, ADDR_W), MEM_WDATA (out, DATA_W) and MEM_RDATA (in, DATA_W).
REQ-008 The board I/O SHALL be SW (in, 8, asynchronous switches) and LED (out, 8).

Function
REQ-009 A requester SHALL hold REQ high and its address and data stable until ACK; the block SHALL sample REQ only in IDLE.
REQ-010 The FSM SHALL have the states IDLE, MEM_ISSUE, MEM_WAIT, MMIO and RESP; it SHALL return to IDLE after RESP.
REQ-011 In IDLE, LS SHALL win over IF, unless the starvation count equals 3 and IF_REQ is high, in which case IF SHALL win.
REQ-012 The starvation count (2-bit) SHALL increment on each LS grant while IF_REQ is high, saturate at 3, and clear on any IF grant or on an LS grant while IF_REQ is low.
REQ-013 On a grant at cycle t, the block SHALL register the address, write enable and data, and drive MEM_EN=1 for exactly cycle t+1 (MEM_ISSUE); MEM_WE SHALL equal LS_BE on a store and 0 otherwise.
REQ-014 MEM_WAIT SHALL count MEM_LAT cycles; MEM_RDATA SHALL be captured at t+1+MEM_LAT, with the matching ACK pulsed and RDATA valid in that cycle (RESP).
REQ-015 A store SHALL still receive an ACK with the same timing, and LS_RDATA SHALL be 0 on a store.
REQ-016 IF_RDATA and LS_RDATA SHALL hold their last value between ACKs; the ACK not being served SHALL stay 0.
REQ-017 Throughput per requester SHALL be at most one transaction per MEM_LAT+2 cycles; a REQ held high through its ACK SHALL be treated as a new request.
REQ-018 Outside the MMIO case, MEM_EN SHALL be 0 in every state except MEM_ISSUE.

Reset
REQ-019 RST_N low SHALL force, immediately: FSM to IDLE, all ACKs 0, MEM_EN 0, MEM_WE 0, MEM_ADDR/MEM_WDATA 0, RDATA outputs 0, starvation count 0, LED 0 and the SW synchronizer to 0.
REQ-020 An in-flight transaction interrupted by reset SHALL be dropped, with no ACK ever issued for it; the requester SHALL re-request.

Configuration
REQ-021 With MEM_ARB_MMIO_EN defined, an LS access with LS_ADDR[ADDR_W-1:8] all ones SHALL go to MMIO state with no MEM_EN and ACK at t+1.
REQ-022 In MMIO, a store with LS_BE[0]=1 SHALL load LED from LS_WDATA[7:0], and a load SHALL return {24'b0, SW} from a 2-flop synchronizer.
REQ-023 IF accesses SHALL never decode as MMIO.
REQ-024 Without MEM_ARB_MMIO_EN, all addresses SHALL go to memory, LED SHALL be tied to 0 and SW SHALL be unused.

Structure
REQ-025 The package mem_arbiter_pkg SHALL hold the FSM state enum, MMIO_BASE_HI (all-ones upper-address constant) and STARVE_MAX=3.
REQ-026 The single sub-module sync2 SHALL be the 2-flop synchronizer for SW, instantiated only under MEM_ARB_MMIO_EN.

Verification
REQ-027 The bench SHALL cover: MEM_LAT=1, IF_REQ alone at 0x100 with MEM_RDATA=0xDEADBEEF -> MEM_EN at t+1, IF_ACK at t+2, IF_RDATA=0xDEADBEEF.
REQ-028 The bench SHALL cover: IF_REQ and LS_REQ held high continuously -> grant order LS,LS,LS,IF repeating, with no IF wait longer than 3 LS transactions.
REQ-029 The bench SHALL cover: LS store 0x11223344 to 0x40 with LS_BE=4'b0011 -> MEM_WE=4'b0011, LS_ACK pulsed and LS_RDATA=0.
REQ-030 The bench SHALL cover: MEM_LAT=3 with an LS load -> LS_ACK exactly 4 cycles after the grant cycle.
REQ-031 The bench SHALL cover: RST_N pulsed low during MEM_WAIT -> no ACK, outputs at reset values, and a fresh request served normally afterwards.
REQ-032 The bench SHALL cover, with MEM_ARB_MMIO_EN: store 0xA5 to 0xFFFFFF00 -> LED=0xA5 with MEM_EN 0; load from the same address with SW=8'h55 -> LS_RDATA=0x00000055.
